// File: rtl/lsu_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_wb_if
// Description : Wishbone classic bus bundle between the load/store unit
//               (master) and the data-side slave.
//               o_wb_addr  byte address, lane-aligned
//               o_wb_cyc   bus cycle in progress
//               o_wb_stb   strobe, follows o_wb_cyc
//               o_wb_sel   lane select, MSB lane = byte offset 0
//               o_wb_we    write enable
//               o_wb_dat   write data, lane-positioned
//               i_wb_dat   read data
//               i_wb_ack   transfer acknowledge
//               i_wb_err   transfer error
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_wb_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   localparam int NB = DW / 8;

   logic [AW-1:0] o_wb_addr;
   logic          o_wb_cyc;
   logic          o_wb_stb;
   logic [NB-1:0] o_wb_sel;
   logic          o_wb_we;
   logic [DW-1:0] o_wb_dat;
   logic [DW-1:0] i_wb_dat;
   logic          i_wb_ack;
   logic          i_wb_err;

   modport master (
      output o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_sel, o_wb_we, o_wb_dat,
      input  i_wb_dat, i_wb_ack, i_wb_err
   );

   modport slave (
      input  o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_sel, o_wb_we, o_wb_dat,
      output i_wb_dat, i_wb_ack, i_wb_err
   );
endinterface
`default_nettype wire

// File: rtl/lsu_wb.sv
`default_nettype none
// ============================================================================
// Module      : lsu_wb
// Description : Load/store unit. Turns one CPU memory request into one
//               Wishbone classic read or write with byte/half/word/dword
//               sizes, sign/zero extension on loads, a misalignment trap and
//               a bus timeout. Big-endian lanes: byte offset 0 is the MSB lane.
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_req/i_we/i_size       request strobe (taken in IDLE), store flag, size
//   i_signed                sign-extend loads
//   i_addr/i_wdata          byte address, right-justified store data
//   o_busy                  access in flight on the bus
//   o_data                  last load result, right-justified and extended
//   o_valid/o_error         one-cycle completion / failure pulses
//   o_err_code              01 misaligned, 10 bus error, 11 timeout
//   wb                      Wishbone master port
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_wb #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_req,
   input  logic          i_we,
   input  logic [1:0]    i_size,
   input  logic          i_signed,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_busy,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   output logic          o_error,
   output logic [1:0]    o_err_code,
   lsu_wb_if.master      wb
);
   localparam int NB = DW / 8;
   localparam int OB = $clog2(NB);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [NB-1:0] sel_q, sel_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdat_q, wdat_d;
   logic [1:0]    size_q, size_d;
   logic          signed_q, signed_d;
   logic [OB-1:0] lsh_q, lsh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          error_q, error_d;
   logic [1:0]    code_q, code_d;

   // Mask of the low bytes covered by an access of the given size.
   function automatic logic [DW-1:0] field_mask(input logic [1:0] size);
      logic [DW-1:0] m;
      case (size)
         2'b00:   m = DW'(8'hFF);
         2'b01:   m = DW'(16'hFFFF);
         2'b10:   m = DW'(32'hFFFF_FFFF);
         default: m = '1;
      endcase
      return m;
   endfunction

   // Request decode
   logic [2:0]    req_amask;
   logic [2:0]    req_lanes_m1;
   logic          req_misal;
   logic [OB-1:0] req_lsh;
   logic [NB-1:0] req_sel;
   logic [DW-1:0] req_dat;

   always_comb begin
      case (i_size)
         2'b00:   begin req_amask = 3'b000; req_lanes_m1 = 3'd0; req_sel = NB'(1);    end
         2'b01:   begin req_amask = 3'b001; req_lanes_m1 = 3'd1; req_sel = NB'(3);    end
         2'b10:   begin req_amask = 3'b011; req_lanes_m1 = 3'd3; req_sel = NB'(4'hF); end
         default: begin req_amask = 3'b111; req_lanes_m1 = 3'd7; req_sel = '1;       end
      endcase
      req_misal = ((i_addr[2:0] & req_amask) != 3'b000) || (i_size == 2'b11 && DW == 32);
      // Lowest selected lane = (NB-1-off) - (lanes-1); modulo-NB arithmetic is
      // exact for every aligned access.
      req_lsh = ~i_addr[OB-1:0] - OB'(req_lanes_m1);
      req_sel = req_sel << req_lsh;
      req_dat = (i_wdata & field_mask(i_size)) << {req_lsh, 3'b000};
   end

   // Load extraction: bring the selected lanes down to the LSBs and extend.
   logic [DW-1:0] ld_mask;
   logic [DW-1:0] ld_raw;
   logic          ld_sign;
   logic [DW-1:0] ld_val;

   always_comb begin
      ld_mask = field_mask(size_q);
      ld_raw  = (wb.i_wb_dat >> {lsh_q, 3'b000}) & ld_mask;
      // Top bit of a contiguous low mask is mask & ~(mask >> 1).
      ld_sign = |(ld_raw & ld_mask & ~(ld_mask >> 1));
      ld_val  = (signed_q && ld_sign) ? (ld_raw | ~ld_mask) : ld_raw;
   end

   // Next-state and output logic
   logic bus_done;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      sel_d    = sel_q;
      we_d     = we_q;
      wdat_d   = wdat_q;
      size_d   = size_q;
      signed_d = signed_q;
      lsh_d    = lsh_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      error_d  = 1'b0;
      code_d   = code_q;
      bus_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_req) begin
               if (req_misal) begin
                  error_d = 1'b1;
                  code_d  = 2'b01;
               end else begin
                  state_d  = BUS;
                  addr_d   = {i_addr[AW-1:OB], {OB{1'b0}}};
                  sel_d    = req_sel;
                  we_d     = i_we;
                  wdat_d   = req_dat;
                  size_d   = i_size;
                  signed_d = i_signed;
                  lsh_d    = req_lsh;
                  cnt_d    = '0;
               end
            end
         end
         BUS: begin
            // err takes priority over a simultaneous ack
            if (wb.i_wb_err) begin
               error_d  = 1'b1;
               code_d   = 2'b10;
               bus_done = 1'b1;
            end else if (wb.i_wb_ack) begin
               valid_d  = 1'b1;
               bus_done = 1'b1;
               if (!we_q) begin
                  data_d = ld_val;
               end
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               error_d  = 1'b1;
               code_d   = 2'b11;
               bus_done = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus_done) begin
               state_d = IDLE;
               sel_d   = '0;
               we_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         wdat_q   <= '0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         lsh_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         code_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         wdat_q   <= wdat_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         lsh_q    <= lsh_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         code_q   <= code_d;
      end
   end

   // Bus and status outputs come straight from registers.
   assign wb.o_wb_cyc  = (state_q == BUS);
   assign wb.o_wb_stb  = (state_q == BUS);
   assign wb.o_wb_addr = addr_q;
   assign wb.o_wb_sel  = sel_q;
   assign wb.o_wb_we   = we_q;
   assign wb.o_wb_dat  = wdat_q;
   assign o_busy       = (state_q == BUS);
   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_error      = error_q;
   assign o_err_code   = code_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_wb
// Description : Self-checking bench for lsu_wb. Drives a DW=32 and a DW=64
//               instance (both TIMEOUT=4) from a vector table, hand-written
//               corner sequences and random traffic scored by a byte-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_wb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req32, req64, we_r, sgn_r, ack, err;
   logic [1:0]  size_r;
   logic [31:0] addr_r;
   logic [63:0] wdata_r, rdata_r;
   bit          use_64;

   int checks = 0;
   int errors = 0;
   logic [63:0] last32 = '0;
   logic [63:0] last64 = '0;

   always #5 clk = ~clk;

   lsu_wb_if #(.DW(32), .AW(32)) bus32 ();
   lsu_wb_if #(.DW(64), .AW(32)) bus64 ();

   assign bus32.i_wb_dat = rdata_r[31:0];
   assign bus32.i_wb_ack = ack;
   assign bus32.i_wb_err = err;
   assign bus64.i_wb_dat = rdata_r;
   assign bus64.i_wb_ack = ack;
   assign bus64.i_wb_err = err;

   logic        busy32, valid32, error32, busy64, valid64, error64;
   logic [31:0] data32;
   logic [63:0] data64;
   logic [1:0]  code32, code64;

   lsu_wb #(.DW(32), .AW(32), .TIMEOUT(4)) dut32 (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req32), .i_we(we_r), .i_size(size_r),
      .i_signed(sgn_r), .i_addr(addr_r), .i_wdata(wdata_r[31:0]),
      .o_busy(busy32), .o_data(data32), .o_valid(valid32), .o_error(error32),
      .o_err_code(code32), .wb(bus32));

   lsu_wb #(.DW(64), .AW(32), .TIMEOUT(4)) dut64 (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req64), .i_we(we_r), .i_size(size_r),
      .i_signed(sgn_r), .i_addr(addr_r), .i_wdata(wdata_r),
      .o_busy(busy64), .o_data(data64), .o_valid(valid64), .o_error(error64),
      .o_err_code(code64), .wb(bus64));

   // View of whichever instance the current access targets
   logic        m_busy, m_valid, m_error, m_cyc, m_stb, m_we;
   logic [1:0]  m_code;
   logic [7:0]  m_sel;
   logic [31:0] m_addr;
   logic [63:0] m_data, m_wdat;
   assign m_busy  = use_64 ? busy64  : busy32;
   assign m_valid = use_64 ? valid64 : valid32;
   assign m_error = use_64 ? error64 : error32;
   assign m_code  = use_64 ? code64  : code32;
   assign m_data  = use_64 ? data64  : {32'h0, data32};
   assign m_cyc   = use_64 ? bus64.o_wb_cyc  : bus32.o_wb_cyc;
   assign m_stb   = use_64 ? bus64.o_wb_stb  : bus32.o_wb_stb;
   assign m_we    = use_64 ? bus64.o_wb_we   : bus32.o_wb_we;
   assign m_sel   = use_64 ? bus64.o_wb_sel  : {4'h0, bus32.o_wb_sel};
   assign m_addr  = use_64 ? bus64.o_wb_addr : bus32.o_wb_addr;
   assign m_wdat  = use_64 ? bus64.o_wb_dat  : {32'h0, bus32.o_wb_dat};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (byte-offset view) ----------------
   function automatic logic [7:0] mdl_sel(input int nb, input int off, input int n);
      logic [7:0] s = '0;
      for (int k = off; k < off + n; k++) s = s | (8'h01 << (nb - 1 - k));
      return s;
   endfunction

   function automatic logic [63:0] mdl_wdat(input int nb, input int off, input int n,
                                            input logic [63:0] wd);
      logic [63:0] w = '0;
      // byte offset off+i receives data byte n-1-i (most significant first)
      for (int i = 0; i < n; i++)
         w = w | (((wd >> (8 * (n - 1 - i))) & 64'hFF) << (8 * (nb - 1 - off - i)));
      return w;
   endfunction

   function automatic logic [63:0] mdl_load(input int nb, input int off, input int n,
                                            input bit sg, input logic [63:0] rd);
      logic [63:0] v = '0;
      logic [63:0] m;
      for (int i = 0; i < n; i++)
         v = (v << 8) | ((rd >> (8 * (nb - 1 - off - i))) & 64'hFF);
      m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
      if (sg && ((v >> (8 * n - 1)) & 64'd1) != 64'd0) v = v | ~m;
      if (nb == 4) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   // resp: 0 ack, 1 err, 2 ack+err, 3 no response (timeout)
   task automatic run_txn(input string nm, input bit u64, input bit we, input logic [1:0] sz,
                          input bit sg, input logic [31:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input int resp, input int dly,
                          input logic [7:0] e_sel, input logic [63:0] e_wdat,
                          input logic [1:0] e_code, input logic [63:0] e_data);
      int n;
      logic [31:0] amask;
      amask = u64 ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
      use_64 = u64; we_r = we; size_r = sz; sgn_r = sg; addr_r = a; wdata_r = wd; rdata_r = rd;
      if (u64) req64 = 1'b1; else req32 = 1'b1;
      step();
      req32 = 1'b0; req64 = 1'b0;
      if (e_code == 2'b01) begin
         chk({nm, " misal error"}, m_error, 1);
         chk({nm, " misal code"}, m_code, 2'b01);
         chk({nm, " misal cyc"}, m_cyc, 0);
         chk({nm, " misal busy"}, m_busy, 0);
      end else begin
         chk({nm, " cyc"}, m_cyc, 1);
         chk({nm, " stb"}, m_stb, 1);
         chk({nm, " busy"}, m_busy, 1);
         chk({nm, " sel"}, m_sel, e_sel);
         chk({nm, " we"}, m_we, we);
         chk({nm, " addr"}, m_addr, a & amask);
         if (we) chk({nm, " wdat"}, m_wdat, e_wdat);
         if (resp == 3) begin
            n = 1;
            while (m_cyc && n < 40) begin
               step();
               if (m_cyc) n++;
            end
            chk({nm, " cyc cycles"}, n, 4);
         end else begin
            repeat (dly) step();
            chk({nm, " cyc held"}, m_cyc, 1);
            ack = (resp == 0 || resp == 2);
            err = (resp == 1 || resp == 2);
            step();
            ack = 1'b0; err = 1'b0;
         end
         chk({nm, " valid"}, m_valid, e_code == 2'b00);
         chk({nm, " error"}, m_error, e_code != 2'b00);
         if (e_code != 2'b00) chk({nm, " code"}, m_code, e_code);
         chk({nm, " data"}, m_data, e_data);
         chk({nm, " cyc drop"}, m_cyc, 0);
         chk({nm, " busy drop"}, m_busy, 0);
      end
      step();
      chk({nm, " pulse end"}, {m_valid, m_error}, 2'b00);
   endtask

   task automatic rand_txn(input bit u64);
      int nb, n, off, r, resp;
      logic [1:0] sz, code;
      logic [31:0] a;
      bit we, sg, mis;
      logic [63:0] wd, rd, ed, last;
      nb = u64 ? 8 : 4;
      if (u64) sz = 2'($urandom_range(0, 3));
      else sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      n  = 1 << sz;
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      r  = $urandom_range(0, 9);
      resp = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      mis  = (n > nb) || ((a % 32'(n)) != 0);
      off  = int'(a % 32'(nb));
      last = u64 ? last64 : last32;
      code = mis ? 2'b01 : (resp != 0) ? 2'b10 : 2'b00;
      ed   = last;
      if (code == 2'b00 && !we) ed = mdl_load(nb, off, n, sg, rd);
      run_txn(u64 ? "rnd64" : "rnd32", u64, we, sz, sg, a, wd, rd, resp, $urandom_range(0, 2),
              mis ? 8'h00 : mdl_sel(nb, off, n), mis ? 64'h0 : mdl_wdat(nb, off, n, wd),
              code, ed);
      if (u64) last64 = ed; else last32 = ed;
   endtask

   typedef struct {
      bit          u64;
      bit          we;
      logic [1:0]  size;
      bit          sgn;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          resp;
      logic [7:0]  e_sel;
      logic [63:0] e_wdat;
      logic [1:0]  e_code;
      logic [63:0] e_data;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req32 = 1'b0; req64 = 1'b0; we_r = 1'b0; sgn_r = 1'b0; ack = 1'b0; err = 1'b0;
      size_r = 2'b00; addr_r = '0; wdata_r = '0; rdata_r = '0; use_64 = 1'b0;

      tbl.push_back('{0, 0, 2'b00, 1, 32'h1003, 64'h0, 64'h123456F0, 0, 8'h01, 64'h0, 2'b00, 64'hFFFFFFF0});
      tbl.push_back('{0, 1, 2'b01, 0, 32'h2002, 64'hABCD, 64'h0, 0, 8'h03, 64'h0000ABCD, 2'b00, 64'hFFFFFFF0});
      tbl.push_back('{0, 0, 2'b10, 0, 32'h3001, 64'h0, 64'h0, 0, 8'h00, 64'h0, 2'b01, 64'hFFFFFFF0});
      tbl.push_back('{0, 0, 2'b10, 0, 32'h4000, 64'h0, 64'h11223344, 2, 8'h0F, 64'h0, 2'b10, 64'hFFFFFFF0});
      tbl.push_back('{0, 0, 2'b01, 0, 32'h5000, 64'h0, 64'h80011234, 0, 8'h0C, 64'h0, 2'b00, 64'h00008001});
      tbl.push_back('{0, 0, 2'b01, 1, 32'h5002, 64'h0, 64'h80011234, 0, 8'h03, 64'h0, 2'b00, 64'h00001234});
      tbl.push_back('{0, 0, 2'b00, 0, 32'h6001, 64'h0, 64'h12AB5678, 0, 8'h04, 64'h0, 2'b00, 64'h000000AB});
      tbl.push_back('{0, 0, 2'b00, 1, 32'h6001, 64'h0, 64'h12AB5678, 0, 8'h04, 64'h0, 2'b00, 64'hFFFFFFAB});
      tbl.push_back('{0, 1, 2'b00, 0, 32'h7001, 64'h1155, 64'h0, 0, 8'h04, 64'h00550000, 2'b00, 64'hFFFFFFAB});
      tbl.push_back('{0, 1, 2'b10, 0, 32'h7004, 64'hDEADBEEF, 64'h0, 0, 8'h0F, 64'hDEADBEEF, 2'b00, 64'hFFFFFFAB});
      tbl.push_back('{0, 0, 2'b11, 0, 32'h0008, 64'h0, 64'h0, 0, 8'h00, 64'h0, 2'b01, 64'hFFFFFFAB});
      tbl.push_back('{0, 0, 2'b10, 0, 32'h9000, 64'h0, 64'h0, 3, 8'h0F, 64'h0, 2'b11, 64'hFFFFFFAB});
      tbl.push_back('{0, 0, 2'b10, 0, 32'h9004, 64'h0, 64'h55AA55AA, 1, 8'h0F, 64'h0, 2'b10, 64'hFFFFFFAB});
      tbl.push_back('{1, 0, 2'b11, 0, 32'h0008, 64'h0, 64'h0123456789ABCDEF, 0, 8'hFF, 64'h0, 2'b00, 64'h0123456789ABCDEF});
      tbl.push_back('{1, 0, 2'b10, 1, 32'h000C, 64'h0, 64'h0123456789ABCDEF, 0, 8'h0F, 64'h0, 2'b00, 64'hFFFFFFFF89ABCDEF});
      tbl.push_back('{1, 0, 2'b01, 0, 32'h0002, 64'h0, 64'h0123456789ABCDEF, 0, 8'h30, 64'h0, 2'b00, 64'h0000000000004567});
      tbl.push_back('{1, 1, 2'b00, 0, 32'h000F, 64'h5A, 64'h0, 0, 8'h01, 64'h5A, 2'b00, 64'h4567});
      tbl.push_back('{1, 1, 2'b10, 0, 32'h0004, 64'h11223344, 64'h0, 0, 8'h0F, 64'h11223344, 2'b00, 64'h4567});
      tbl.push_back('{1, 1, 2'b01, 0, 32'h0006, 64'hBEEF, 64'h0, 0, 8'h03, 64'hBEEF, 2'b00, 64'h4567});
      tbl.push_back('{1, 1, 2'b11, 0, 32'h0010, 64'hA1B2C3D4E5F60718, 64'h0, 0, 8'hFF, 64'hA1B2C3D4E5F60718, 2'b00, 64'h4567});
      tbl.push_back('{1, 0, 2'b11, 0, 32'h0004, 64'h0, 64'h0, 0, 8'h00, 64'h0, 2'b01, 64'h4567});
      tbl.push_back('{1, 0, 2'b10, 0, 32'h0020, 64'h0, 64'h0, 3, 8'hF0, 64'h0, 2'b11, 64'h4567});

      repeat (3) step();
      // Reset state of both instances
      for (int u = 0; u < 2; u++) begin
         use_64 = (u == 1);
         chk("reset cyc", m_cyc, 0);
         chk("reset busy", m_busy, 0);
         chk("reset pulses", {m_valid, m_error}, 2'b00);
         chk("reset data", m_data, 0);
         chk("reset code", m_code, 0);
         chk("reset sel/we", {m_sel, m_we}, 0);
      end
      rst_n = 1'b1;
      step();

      for (int i = 0; i < tbl.size(); i++) begin
         run_txn($sformatf("vec%0d", i), tbl[i].u64, tbl[i].we, tbl[i].size, tbl[i].sgn,
                 tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].resp, i % 3, tbl[i].e_sel,
                 tbl[i].e_wdat, tbl[i].e_code, tbl[i].e_data);
         if (tbl[i].u64) last64 = tbl[i].e_data; else last32 = tbl[i].e_data;
      end

      // Request during BUS is dropped; next request accepted in the o_valid cycle
      use_64 = 1'b0; we_r = 1'b0; size_r = 2'b10; sgn_r = 1'b0; addr_r = 32'h200;
      req32 = 1'b1; step(); req32 = 1'b0;
      chk("ign cyc", m_cyc, 1);
      addr_r = 32'h301; req32 = 1'b1; step(); req32 = 1'b0;
      chk("ign no error", m_error, 0);
      chk("ign addr kept", m_addr, 32'h200);
      rdata_r = 64'hCAFEBABE; ack = 1'b1; step(); ack = 1'b0;
      chk("b2b valid", m_valid, 1);
      chk("b2b data", m_data, 64'hCAFEBABE);
      size_r = 2'b00; addr_r = 32'h203; req32 = 1'b1; step(); req32 = 1'b0;
      chk("b2b cyc again", m_cyc, 1);
      chk("b2b sel", m_sel, 8'h01);
      chk("b2b valid pulse", m_valid, 0);
      rdata_r = 64'h1234569C; ack = 1'b1; step(); ack = 1'b0;
      chk("b2b byte data", m_data, 64'h9C);
      step();
      chk("b2b idle", {m_cyc, m_valid}, 2'b00);
      ack = 1'b1; err = 1'b1; step(); ack = 1'b0; err = 1'b0; step();
      chk("idle ack ignored", {m_valid, m_error, m_cyc}, 3'b000);
      last32 = 64'h9C;

      // Reset asserted in the middle of a bus cycle
      addr_r = 32'h400; size_r = 2'b10; req32 = 1'b1; step(); req32 = 1'b0;
      chk("rst mid cyc before", m_cyc, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst mid cyc", m_cyc, 0);
      chk("rst mid busy", m_busy, 0);
      chk("rst mid data", m_data, 0);
      step();
      chk("rst mid pulses", {m_valid, m_error}, 2'b00);
      rst_n = 1'b1;
      step();
      chk("rst after cyc", m_cyc, 0);
      last32 = '0; last64 = '0;

      for (int i = 0; i < 150; i++) rand_txn(1'b0);
      for (int i = 0; i < 150; i++) rand_txn(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
